dec_8b10b: RTL
==============

# dec_8b10b

Receive-side 8b/10b decoder paired with `encoder_8b10b`. It accepts 10-bit code words qualified by `in_valid` and inverts both disparity columns of the shared code tables back to bytes. It tracks running disparity with the same rule as the transmitter and flags invalid codes and disparity violations. A sync state machine and a saturating error counter report link health. It sits directly after the deserializer in the receive path.

## Interface
- `GOOD_WORDS`, default 4: consecutive error-free words needed to enter SYNC.
- `BAD_WORDS`, default 4: consecutive errored words that force a return to ACQ.
- `ERR_CNT_W`, default 16: width of the error counter.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: `code_in` is valid this cycle.
- `code_in`  in  10: code word. [9:4] is the 6b sub-block (byte bits [4:0]); [3:0] is the 4b sub-block (byte bits [7:5]).
- `err_clr`  in  1: synchronous clear of `err_cnt`.
- `out_valid`  out  1: the output registers below hold a newly decoded word.
- `data_out`  out  8: decoded byte.
- `code_err`  out  1: a sub-block is absent from both columns.
- `disp_err`  out  1: the code is legal, but a sub-block is absent from the column for the current `rd`.
- `rd`  out  1: running disparity after the last word.
- `in_sync`  out  1: FSM is in SYNC.
- `err_cnt`  out  `ERR_CNT_W`: saturating count of words with `code_err` or `disp_err` set.

## Operation
- **Lookup:** 6b and 4b sub-blocks are each looked up in the rd=0 and rd=1 columns of the shared tables.
  - A sub-block found in either column decodes to its value; the current-`rd` column is preferred on a double match.
  - The 3-bit value goes to `data_out[7:5]` and the 5-bit value to `data_out[4:0]`.
- **code_err:** set if either sub-block matches neither column. On `code_err`, `data_out` is 8'h00.
- **disp_err:** set only in SYNC, only when `code_err`=0, and only if either sub-block is missing from the column selected by the current `rd`. In ACQ it is always 0.
- **Disparity update:** on every accepted word, including errored ones:
  - ones = popcount(`code_in`), computed in 4 bits;
  - `rd` <= 1 if ones>5, 0 if ones<5, unchanged if ones==5.
- **FSM:** states ACQ and SYNC; reset state is ACQ. Internal counters `good_run` and `bad_run` count consecutive good and errored words and saturate at their parameter values.
  - A good word clears `bad_run`; an errored word clears `good_run`.
  - ACQ -> SYNC when `good_run` reaches `GOOD_WORDS` with the current word good.
  - SYNC -> ACQ when `bad_run` reaches `BAD_WORDS`.
  - On each transition both run counters clear.
- **err_cnt:** increments per errored word and saturates at all-ones.
  - `err_clr` has priority over an increment in the same cycle; the result is 0.
- **No input:** with `in_valid`=0, `out_valid`=0 and all other state holds.

## Timing
- Latency is 1 cycle. A word sampled on edge N appears on all outputs after edge N, with `out_valid`=1 for that single cycle.
- Back-to-back words are accepted every cycle. There is no backpressure.
- `in_sync` changes after the edge that samples the deciding word.
- Reset values: `out_valid`=0, `data_out`=0, `code_err`=0, `disp_err`=0, `rd`=0, `in_sync`=0, `err_cnt`=0, FSM in ACQ, run counters 0.
- Reset asserted mid-stream aborts immediately. The first valid word after release is checked against `rd`=0.

## Structure
- Shared package `pkg_8b10b`, common with the encoder:
  - 6b tables `ENC6_RD0[32]` and `ENC6_RD1[32]`;
  - 4b tables `ENC4_RD0[8]` and `ENC4_RD1[8]`;
  - a popcount function;
  - FSM state typedef.
- Encoder and decoder both reference these tables; no duplicated literals.
- One sub-module, `dec_8b10b_lut`: purely combinational. Inputs are the sub-blocks and current `rd`. Outputs are the decoded value, found_any and found_in_rd flags for each sub-block.
- The top level holds the registers, FSM and counters.

## Test plan
- **Decode at rd=0:** reset, then `code_in`=10'h27B -> `data_out`=8'h00, `rd`=1, both errors 0. Then 10'h184 -> `data_out`=8'h00, `rd`=0.
- **Balanced word:** with `rd`=1, `code_in`=10'h319 -> `data_out`=8'h23, `rd` stays 1.
- **Code error:** `code_in`=10'h000 -> `code_err`=1, `data_out`=8'h00, `err_cnt` increments by 1, `rd`=0.
- **Sync and disparity error:** 4 legal alternating words (0x27B/0x184) -> `in_sync`=1 after the 4th. Then drive `rd`=1 and send 0x27B -> `disp_err`=1, `data_out`=8'h00, `rd`=1.
- **Sync loss and counter:**
  - 4 consecutive 10'h000 in SYNC -> `in_sync`=0 after the 4th.
  - With `ERR_CNT_W`=2, 5 errors -> `err_cnt`=3 (saturated).
  - `err_clr` together with an error -> `err_cnt`=0.
- **Idle and mid-stream reset:** `in_valid`=0 gaps -> `out_valid`=0 and state holds. Reset mid-stream -> all outputs 0 asynchronously; next 0x27B decodes cleanly.

Source files
------------

// File: rtl/pkg_8b10b.sv
// Shared 8b/10b definitions used by both the encoder and decoder: code tables,
// popcount helper and the receive sync FSM state type.
package pkg_8b10b;

  typedef enum logic {
    ST_ACQ  = 1'b0,
    ST_SYNC = 1'b1
  } sync_state_t;

  // 6b sub-blocks, bit 5 = a ... bit 0 = i, indexed by byte bits [4:0]
  localparam logic [5:0] ENC6_RD0 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
  };

  localparam logic [5:0] ENC6_RD1 [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100
  };

  // 4b sub-blocks, bit 3 = f ... bit 0 = j, indexed by byte bits [7:5]
  localparam logic [3:0] ENC4_RD0 [8] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110
  };

  localparam logic [3:0] ENC4_RD1 [8] = '{
    4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001
  };

  function automatic logic [3:0] popcount10(input logic [9:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/dec_8b10b_if.sv
// Receive-side word bus between deserializer, decoder and downstream logic.
interface dec_8b10b_if #(
  parameter int unsigned ERR_CNT_W = 16
);
  logic                 in_valid;
  logic [9:0]           code_in;
  logic                 err_clr;
  logic                 out_valid;
  logic [7:0]           data_out;
  logic                 code_err;
  logic                 disp_err;
  logic                 rd;
  logic                 in_sync;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output in_valid, code_in, err_clr,
    input  out_valid, data_out, code_err, disp_err, rd, in_sync, err_cnt
  );

  modport slave (
    input  in_valid, code_in, err_clr,
    output out_valid, data_out, code_err, disp_err, rd, in_sync, err_cnt
  );
endinterface

// File: rtl/dec_8b10b_lut.sv
// Combinational reverse lookup of 6b and 4b sub-blocks in both disparity columns.
module dec_8b10b_lut
  import pkg_8b10b::*;
(
  input  logic [5:0] sb6,
  input  logic [3:0] sb4,
  input  logic       rd,
  output logic [4:0] val5,
  output logic [2:0] val3,
  output logic       found6_any,
  output logic       found6_rd,
  output logic       found4_any,
  output logic       found4_rd
);

  logic [4:0] v6_cur, v6_alt;
  logic [2:0] v4_cur, v4_alt;
  logic       h6_cur, h6_alt, h4_cur, h4_alt;

  always_comb begin
    v6_cur = '0;
    v6_alt = '0;
    h6_cur = 1'b0;
    h6_alt = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (sb6 == (rd ? ENC6_RD1[i] : ENC6_RD0[i])) begin
        h6_cur = 1'b1;
        v6_cur = 5'(i);
      end
      if (sb6 == (rd ? ENC6_RD0[i] : ENC6_RD1[i])) begin
        h6_alt = 1'b1;
        v6_alt = 5'(i);
      end
    end
  end

  always_comb begin
    v4_cur = '0;
    v4_alt = '0;
    h4_cur = 1'b0;
    h4_alt = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (sb4 == (rd ? ENC4_RD1[i] : ENC4_RD0[i])) begin
        h4_cur = 1'b1;
        v4_cur = 3'(i);
      end
      if (sb4 == (rd ? ENC4_RD0[i] : ENC4_RD1[i])) begin
        h4_alt = 1'b1;
        v4_alt = 3'(i);
      end
    end
  end

  // Current-rd column wins when a sub-block appears in both columns.
  assign val5       = h6_cur ? v6_cur : v6_alt;
  assign val3       = h4_cur ? v4_cur : v4_alt;
  assign found6_any = h6_cur | h6_alt;
  assign found6_rd  = h6_cur;
  assign found4_any = h4_cur | h4_alt;
  assign found4_rd  = h4_cur;

endmodule

// File: rtl/dec_8b10b.sv
// 8b/10b receive decoder: table lookup, running disparity, sync FSM and
// saturating error counter, one cycle of latency.
module dec_8b10b
  import pkg_8b10b::*;
#(
  parameter int unsigned GOOD_WORDS = 4,
  parameter int unsigned BAD_WORDS  = 4,
  parameter int unsigned ERR_CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  dec_8b10b_if.slave   bus
);

  localparam int unsigned RUN_MAX = (GOOD_WORDS > BAD_WORDS) ? GOOD_WORDS : BAD_WORDS;
  localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [RUN_W-1:0] GOOD_LIM = RUN_W'(GOOD_WORDS);
  localparam logic [RUN_W-1:0] BAD_LIM  = RUN_W'(BAD_WORDS);

  sync_state_t          state_q, state_nxt;
  logic [RUN_W-1:0]     good_q, good_nxt, good_inc;
  logic [RUN_W-1:0]     bad_q, bad_nxt, bad_inc;
  logic                 out_valid_q, code_err_q, disp_err_q, rd_q;
  logic [7:0]           data_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic [4:0] val5;
  logic [2:0] val3;
  logic       f6_any, f6_rd, f4_any, f4_rd;
  logic       code_err_c, disp_err_c, word_bad;
  logic       rd_nxt;
  logic [3:0] ones;

  dec_8b10b_lut u_lut (
    .sb6        (bus.code_in[9:4]),
    .sb4        (bus.code_in[3:0]),
    .rd         (rd_q),
    .val5       (val5),
    .val3       (val3),
    .found6_any (f6_any),
    .found6_rd  (f6_rd),
    .found4_any (f4_any),
    .found4_rd  (f4_rd)
  );

  always_comb begin
    code_err_c = ~(f6_any & f4_any);
    disp_err_c = (state_q == ST_SYNC) & ~code_err_c & ~(f6_rd & f4_rd);
    word_bad   = code_err_c | disp_err_c;
    ones       = popcount10(bus.code_in);
    rd_nxt     = rd_q;
    if (ones > 4'd5) begin
      rd_nxt = 1'b1;
    end else if (ones < 4'd5) begin
      rd_nxt = 1'b0;
    end
    good_inc = (good_q >= GOOD_LIM) ? GOOD_LIM : good_q + 1'b1;
    bad_inc  = (bad_q >= BAD_LIM) ? BAD_LIM : bad_q + 1'b1;
  end

  always_comb begin
    state_nxt = state_q;
    good_nxt  = good_q;
    bad_nxt   = bad_q;
    if (bus.in_valid) begin
      if (word_bad) begin
        good_nxt = '0;
        bad_nxt  = bad_inc;
      end else begin
        good_nxt = good_inc;
        bad_nxt  = '0;
      end
      unique case (state_q)
        ST_ACQ: begin
          if (!word_bad && good_inc == GOOD_LIM) begin
            state_nxt = ST_SYNC;
            good_nxt  = '0;
            bad_nxt   = '0;
          end
        end
        ST_SYNC: begin
          if (word_bad && bad_inc == BAD_LIM) begin
            state_nxt = ST_ACQ;
            good_nxt  = '0;
            bad_nxt   = '0;
          end
        end
        default: state_nxt = ST_ACQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_ACQ;
      good_q      <= '0;
      bad_q       <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      code_err_q  <= 1'b0;
      disp_err_q  <= 1'b0;
      rd_q        <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_nxt;
      good_q      <= good_nxt;
      bad_q       <= bad_nxt;
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        data_q     <= code_err_c ? 8'h00 : {val3, val5};
        code_err_q <= code_err_c;
        disp_err_q <= disp_err_c;
        rd_q       <= rd_nxt;
      end
      if (bus.err_clr) begin
        err_cnt_q <= '0;
      end else if (bus.in_valid && word_bad && err_cnt_q != '1) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_q;
  assign bus.code_err  = code_err_q;
  assign bus.disp_err  = disp_err_q;
  assign bus.rd        = rd_q;
  assign bus.in_sync   = (state_q == ST_SYNC);
  assign bus.err_cnt   = err_cnt_q;

endmodule
